// File: rtl/traffic_lights_multi.sv
// traffic_lights_multi: N-channel traffic light controller with a shared, channel-addressed command port.
// Ports:
//   clk_2k_i    - 2 kHz clock; 1 ms = 2 ticks
//   srst_n_i    - synchronous active-low reset (registered once before use)
//   cmd_type_i  - 0 ON, 1 OFF, 2 UNCONTROLLED, 3 SET_GREEN, 4 SET_RED, 5 SET_YELLOW, 6/7 ignored
//   cmd_valid_i - one-cycle command strobe
//   cmd_chan_i  - target channel index; indices >= CHANNELS are dropped
//   cmd_data_i  - duration in ms for SET_* commands (0 ignored)
//   red_o/yellow_o/green_o - registered per-channel lamps
// Optional build macro TRAFFIC_LIGHTS_BROADCAST_EN: channel 4'hF addresses every channel at once
// and clears all channel timers together so the channels run phase-aligned (CHANNELS <= 15).
module traffic_lights_multi #(
  parameter int CHANNELS              = 2,
  parameter int BLINK_HALF_PERIOD_MS  = 1000,
  parameter int BLINK_GREEN_TIME_TICK = 5,
  parameter int RED_YELLOW_MS         = 2000,
  parameter int DEFAULT_RED_MS        = 5000,
  parameter int DEFAULT_YELLOW_MS     = 2000,
  parameter int DEFAULT_GREEN_MS      = 5000
) (
  input  logic                clk_2k_i,
  input  logic                srst_n_i,
  input  logic [2:0]          cmd_type_i,
  input  logic                cmd_valid_i,
  input  logic [3:0]          cmd_chan_i,
  input  logic [15:0]         cmd_data_i,
  output logic [CHANNELS-1:0] red_o,
  output logic [CHANNELS-1:0] yellow_o,
  output logic [CHANNELS-1:0] green_o
);
  localparam logic [2:0] S_OFF = 3'd0;
  localparam logic [2:0] S_RED = 3'd1;
  localparam logic [2:0] S_RY  = 3'd2;
  localparam logic [2:0] S_GRN = 3'd3;
  localparam logic [2:0] S_GBL = 3'd4;
  localparam logic [2:0] S_YEL = 3'd5;
  localparam logic [2:0] S_UNC = 3'd6;
  localparam logic [2:0] C_ON  = 3'd0;
  localparam logic [2:0] C_OFF = 3'd1;
  localparam logic [2:0] C_UNC = 3'd2;
  localparam logic [2:0] C_SG  = 3'd3;
  localparam logic [2:0] C_SR  = 3'd4;
  localparam logic [2:0] C_SY  = 3'd5;
  localparam logic [16:0] HALF_T = 17'(2 * BLINK_HALF_PERIOD_MS);
  localparam logic [16:0] PER_T  = 17'(4 * BLINK_HALF_PERIOD_MS);
  localparam logic [16:0] RY_T   = 17'(2 * RED_YELLOW_MS);
  localparam logic [16:0] GBL_T  = 17'(4 * BLINK_GREEN_TIME_TICK * BLINK_HALF_PERIOD_MS);
  logic        rst_n_q;
  logic [2:0]  cmd_type_q;
  logic        cmd_valid_q;
  logic [3:0]  cmd_chan_q;
  logic [15:0] cmd_data_q;
  logic [CHANNELS-1:0] red_d, yellow_d, green_d;
  logic [CHANNELS-1:0] red_q, yellow_q, green_q;
  logic bcast;
  always_ff @(posedge clk_2k_i) begin
    rst_n_q     <= srst_n_i;
    cmd_type_q  <= cmd_type_i;
    cmd_valid_q <= cmd_valid_i;
    cmd_chan_q  <= cmd_chan_i;
    cmd_data_q  <= cmd_data_i;
  end
`ifdef TRAFFIC_LIGHTS_BROADCAST_EN
  assign bcast = cmd_valid_q && cmd_chan_q == 4'hF;
  if (CHANNELS > 15) begin : g_bad_cfg
    $error("CHANNELS must be <= 15 when broadcast is enabled");
  end
`else
  assign bcast = 1'b0;
`endif
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [2:0]  st_q, st_d, nxt;
    logic [16:0] tmr_q, tmr_d, blk_q, blk_d, dur;
    logic [15:0] red_ms_q, red_ms_d, ylw_ms_q, ylw_ms_d, grn_ms_q, grn_ms_d;
    logic        hit, cyc_st, expire, clr;
    assign hit = bcast || (cmd_valid_q && cmd_chan_q == 4'(c));
    always_comb begin
      dur = 17'd0;
      nxt = S_RED;
      case (st_q)
        S_RED: begin dur = {red_ms_q, 1'b0}; nxt = S_RY;  end
        S_RY:  begin dur = RY_T;             nxt = S_GRN; end
        S_GRN: begin dur = {grn_ms_q, 1'b0}; nxt = S_GBL; end
        S_GBL: begin dur = GBL_T;            nxt = S_YEL; end
        S_YEL: begin dur = {ylw_ms_q, 1'b0}; nxt = S_RED; end
        default: ;
      endcase
    end
    // OFF and UNCONTROLLED have no duration, so they never expire and hold the timer at 0
    assign cyc_st = dur != 17'd0;
    assign expire = cyc_st && tmr_q == dur - 17'd1;
    always_comb begin
      st_d     = expire ? nxt : st_q;
      red_ms_d = red_ms_q;
      ylw_ms_d = ylw_ms_q;
      grn_ms_d = grn_ms_q;
      clr      = expire;
      if (hit) begin
        case (cmd_type_q)
          C_ON:  if (st_q == S_OFF || st_q == S_UNC) begin st_d = S_RED; clr = 1'b1; end
          C_OFF: begin st_d = S_OFF; clr = 1'b1; end
          C_UNC: begin st_d = S_UNC; clr = 1'b1; end
          C_SG:  if (st_q == S_UNC && cmd_data_q != 16'd0) grn_ms_d = cmd_data_q;
          C_SR:  if (st_q == S_UNC && cmd_data_q != 16'd0) red_ms_d = cmd_data_q;
          C_SY:  if (st_q == S_UNC && cmd_data_q != 16'd0) ylw_ms_d = cmd_data_q;
          default: ;
        endcase
        clr = clr || bcast;
      end
      tmr_d = (clr || !cyc_st) ? 17'd0 : tmr_q + 17'd1;
      // Blink phase restarts at every state entry, so each blink starts with the lamp on
      blk_d = (clr || blk_q == PER_T - 17'd1) ? 17'd0 : blk_q + 17'd1;
    end
    always_ff @(posedge clk_2k_i) begin
      if (!rst_n_q) begin
        st_q     <= S_RED;
        tmr_q    <= 17'd0;
        blk_q    <= 17'd0;
        red_ms_q <= 16'(DEFAULT_RED_MS);
        ylw_ms_q <= 16'(DEFAULT_YELLOW_MS);
        grn_ms_q <= 16'(DEFAULT_GREEN_MS);
      end else begin
        st_q     <= st_d;
        tmr_q    <= tmr_d;
        blk_q    <= blk_d;
        red_ms_q <= red_ms_d;
        ylw_ms_q <= ylw_ms_d;
        grn_ms_q <= grn_ms_d;
      end
    end
    assign red_d[c]    = st_q == S_RED || st_q == S_RY;
    assign yellow_d[c] = st_q == S_RY || st_q == S_YEL || (st_q == S_UNC && blk_q < HALF_T);
    assign green_d[c]  = st_q == S_GRN || (st_q == S_GBL && blk_q < HALF_T);
  end
  always_ff @(posedge clk_2k_i) begin
    if (!rst_n_q) begin
      red_q    <= '0;
      yellow_q <= '0;
      green_q  <= '0;
    end else begin
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
    end
  end
  assign red_o    = red_q;
  assign yellow_o = yellow_q;
  assign green_o  = green_q;
endmodule

// File: tb/tb_traffic_lights_multi.sv
// tb_traffic_lights_multi: directed scoreboard bench for traffic_lights_multi (CHANNELS=2).
module tb_traffic_lights_multi;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       srst_n, cmd_valid;
  logic [2:0] cmd_type;
  logic [3:0] cmd_chan;
  logic [15:0] cmd_data;
  logic [1:0] red, yellow, green;
  traffic_lights_multi #(.CHANNELS(2)) dut (
    .clk_2k_i(clk), .srst_n_i(srst_n), .cmd_type_i(cmd_type), .cmd_valid_i(cmd_valid),
    .cmd_chan_i(cmd_chan), .cmd_data_i(cmd_data), .red_o(red), .yellow_o(yellow), .green_o(green)
  );
  typedef struct packed { int at; int ch; logic [2:0] want; } chk_t;
  chk_t q[$];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [2:0] obs;
  localparam int R0  = 5;
  localparam int N1  = R0 + 48011;
  localparam int S   = N1 + 4100;
  localparam int N5  = S + 4;
  localparam int T   = R0 + 66200;
  localparam int R1  = T + 7;
  localparam int END = R1 + 10010;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void push(int at, int ch, logic [2:0] want);
    chk_t x;
    x.at = at; x.ch = ch; x.want = want;
    q.push_back(x);
  endfunction
  task automatic go(int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic cmd(int t, logic [2:0] ty, logic [3:0] ch, logic [15:0] d);
    go(t);
    cmd_type = ty; cmd_chan = ch; cmd_data = d; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  initial begin
    srst_n = 1'b0; cmd_valid = 1'b0; cmd_type = 3'd0; cmd_chan = 4'd0; cmd_data = 16'd0;
    fork
      begin
        for (int ch = 0; ch < 2; ch++) begin
          push(3, ch, 3'b000); push(4, ch, 3'b000); push(R0, ch, 3'b100);
          push(R0 + 6003, ch, 3'b100); push(R0 + 7003, ch, 3'b100);
          push(R0 + 9999, ch, 3'b100); push(R0 + 10000, ch, 3'b110);
          push(R0 + 13999, ch, 3'b110); push(R0 + 14000, ch, 3'b001); push(R0 + 23999, ch, 3'b001);
          for (int p = 0; p < 5; p++) begin
            push(R0 + 24000 + 4000 * p, ch, 3'b001); push(R0 + 25999 + 4000 * p, ch, 3'b001);
            push(R0 + 26000 + 4000 * p, ch, 3'b000); push(R0 + 27999 + 4000 * p, ch, 3'b000);
          end
          push(R0 + 44000, ch, 3'b010); push(R0 + 47999, ch, 3'b010); push(R0 + 48000, ch, 3'b100);
        end
        push(R0 + 17000, 0, 3'b001);
        go(3);
        srst_n = 1'b1;
        cmd(R0 + 5000, 3'd3, 4'd0, 16'd100);
        cmd(R0 + 6000, 3'd2, 4'd5, 16'd0);
        cmd(R0 + 6001, 3'd6, 4'd0, 16'd0);
        cmd(R0 + 7000, 3'd2, 4'hF, 16'd0);
        cmd(R0 + 7500, 3'd0, 4'd1, 16'd0);
        cmd(R0 + 14500, 3'd3, 4'd0, 16'd100);
        push(N1 + 1, 1, 3'b100); push(N1 + 2, 1, 3'b010); push(N1 + 2001, 1, 3'b010);
        push(N1 + 2002, 1, 3'b000); push(N1 + 4001, 1, 3'b000); push(N1 + 4002, 1, 3'b010);
        push(R0 + 57999, 0, 3'b100); push(R0 + 58000, 0, 3'b110);
        push(R0 + 62000, 0, 3'b001); push(R0 + 65000, 0, 3'b001);
        cmd(N1 - 1, 3'd2, 4'd1, 16'd0);
        push(N5 + 1, 1, 3'b010); push(N5 + 2, 1, 3'b100); push(N5 + 1001, 1, 3'b100);
        push(N5 + 1002, 1, 3'b110); push(N5 + 5001, 1, 3'b110); push(N5 + 5002, 1, 3'b001);
        push(N5 + 7001, 1, 3'b001); push(N5 + 7002, 1, 3'b001); push(N5 + 9001, 1, 3'b001);
        push(N5 + 9002, 1, 3'b000);
        cmd(S, 3'd3, 4'd1, 16'd1000);
        cmd(S + 1, 3'd3, 4'd1, 16'd0);
        cmd(S + 2, 3'd4, 4'd1, 16'd500);
        cmd(S + 3, 3'd0, 4'd1, 16'd0);
        push(R0 + 66002, 0, 3'b001); push(R0 + 66003, 0, 3'b000);
        cmd(R0 + 66000, 3'd1, 4'd0, 16'd0);
        push(R0 + 66102, 0, 3'b000); push(R0 + 66103, 0, 3'b100);
        cmd(R0 + 66100, 3'd0, 4'd0, 16'd0);
        push(T + 1, 0, 3'b100);
        for (int ch = 0; ch < 2; ch++) begin
          push(T + 2, ch, 3'b000); push(R1 - 1, ch, 3'b000); push(R1, ch, 3'b100);
          push(R1 + 1000, ch, 3'b100); push(R1 + 9999, ch, 3'b100); push(R1 + 10000, ch, 3'b110);
        end
        go(T);
        srst_n = 1'b0;
        go(T + 5);
        srst_n = 1'b1;
      end
      begin
        while (cyc < END) begin
          @(negedge clk);
          for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at == cyc) begin
              obs = {red[q[i].ch], yellow[q[i].ch], green[q[i].ch]};
              total++;
              assert (obs === q[i].want) else begin
                bad++;
                $error("FAIL lamps ch%0d @%0d: got ryg=%b expected %b", q[i].ch, cyc, obs, q[i].want);
              end
              q.delete(i);
            end
          end
        end
        total++;
        assert (q.size() == 0) else begin
          bad++;
          $error("FAIL pending: got %0d unchecked entries expected 0", q.size());
        end
      end
    join
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
